subt_pipe: RTL and testbench

SUBT_PIPE -- requirements
Module: subt_pipe

---
 rtl/subt_pkg.sv | 21 ++
 rtl/subt_pipe_if.sv | 30 +++
 rtl/subt_core.sv | 53 +++++
 rtl/subt_pipe.sv | 71 +++++++
 tb/tb_subt_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/subt_pkg.sv
// rtl/subt_pkg.sv - mode encodings and result record shared by the subtract pipeline
package subt_pkg;

    localparam int MAX_WIDTH = 32;

    typedef logic [1:0] subt_mode_t;

    localparam subt_mode_t MODE_ABS     = 2'd0;
    localparam subt_mode_t MODE_WRAP    = 2'd1;
    localparam subt_mode_t MODE_SAT     = 2'd2;
    localparam subt_mode_t MODE_ABS_ALT = 2'd3;

    // diff is sized for the widest legal WIDTH; only the low WIDTH bits are meaningful
    typedef struct packed {
        logic [MAX_WIDTH-1:0] diff;
        logic                 neg;
        logic                 ovf;
        logic                 zero;
    } subt_res_t;

endpackage

// File: rtl/subt_pipe_if.sv
// rtl/subt_pipe_if.sv - operand/result handshake bundle for subt_pipe
interface subt_pipe_if
    import subt_pkg::*;
#(
    parameter int WIDTH = 8
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    subt_mode_t       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             neg;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, x, y, mode, out_ready,
        input  in_ready, out_valid, diff, neg, ovf, zero
    );

    modport slave (
        input  in_valid, x, y, mode, out_ready,
        output in_ready, out_valid, diff, neg, ovf, zero
    );

endinterface

// File: rtl/subt_core.sv
// rtl/subt_core.sv - combinational subtract/compare; mode 2 clamps only when SUBT_PIPE_SAT_EN is defined
module subt_core
    import subt_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  subt_mode_t       mode,
    output subt_res_t        res
);

    logic [WIDTH:0]   xe;
    logic [WIDTH:0]   ye;
    logic [WIDTH:0]   d;
    logic [WIDTH-1:0] mag;
    logic             wrap_ovf;

    // One extra bit holds the exact difference in either signedness
    assign xe = (SIGNED != 0) ? {x[WIDTH-1], x} : {1'b0, x};
    assign ye = (SIGNED != 0) ? {y[WIDTH-1], y} : {1'b0, y};
    assign d  = xe - ye;

    // |d| < 2^WIDTH always, so negating the low WIDTH bits is exact
    assign mag      = d[WIDTH] ? ((~d[WIDTH-1:0]) + WIDTH'(1)) : d[WIDTH-1:0];
    assign wrap_ovf = (SIGNED != 0) ? (d[WIDTH] ^ d[WIDTH-1]) : d[WIDTH];

    always_comb begin
        res      = '0;
        res.diff = MAX_WIDTH'(d[WIDTH-1:0]);
        res.neg  = d[WIDTH];
        res.ovf  = wrap_ovf;
        res.zero = (x == y);
        case (mode)
            MODE_ABS, MODE_ABS_ALT: begin
                res.diff = MAX_WIDTH'(mag);
                res.ovf  = 1'b0;
            end
`ifdef SUBT_PIPE_SAT_EN
            MODE_WRAP: ;
            MODE_SAT: begin
                if (wrap_ovf)
                    res.diff = (SIGNED != 0) ? MAX_WIDTH'({d[WIDTH], {(WIDTH-1){~d[WIDTH]}}})
                                             : '0;
            end
`else
            MODE_WRAP, MODE_SAT: ;
`endif
        endcase
    end

endmodule

// File: rtl/subt_pipe.sv
// rtl/subt_pipe.sv - two-stage valid/ready subtract pipeline around subt_core
// Optional saturating mode 2 is enabled by defining SUBT_PIPE_SAT_EN.
module subt_pipe
    import subt_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic      clk,
    input  logic      rst,
    subt_pipe_if.slave bus
);

    subt_res_t core_res;
    subt_res_t s1_res;
    subt_res_t s2_res;
    logic      s1_valid;
    logic      s2_valid;
    logic      accept;
    logic      advance;

    subt_core #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_core (
        .x    (bus.x),
        .y    (bus.y),
        .mode (bus.mode),
        .res  (core_res)
    );

    assign bus.in_ready = rst | ~s1_valid | ~s2_valid | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready;
    assign advance      = s1_valid & (~s2_valid | bus.out_ready);

    // Whenever a beat is accepted into a full S1, S1 is guaranteed to be advancing
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_res   <= '0;
            s2_res   <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_res   <= core_res;
            end else if (advance) begin
                s1_valid <= 1'b0;
            end

            if (advance) begin
                s2_valid <= 1'b1;
                s2_res   <= s1_res;
            end else if (bus.out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = s2_valid & ~rst;
    assign bus.diff      = rst ? '0 : s2_res.diff[WIDTH-1:0];
    assign bus.neg       = s2_res.neg & ~rst;
    assign bus.ovf       = s2_res.ovf & ~rst;
    assign bus.zero      = s2_res.zero & ~rst;

    if (WIDTH < MAX_WIDTH) begin : g_pad
        logic unused_diff_hi;
        assign unused_diff_hi = ^s2_res.diff[MAX_WIDTH-1:WIDTH];
    end

endmodule

// File: tb/tb_subt_pipe.sv
// tb/tb_subt_pipe.sv - directed and random checks of subt_pipe, unsigned and signed instances side by side
module tb_subt_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [1:0]  m;
        logic [10:0] eu;
        logic [10:0] es;
    } vec_t;

    subt_pipe_if #(.WIDTH(8)) u_if ();
    subt_pipe_if #(.WIDTH(8)) s_if ();

    subt_pipe #(.WIDTH(8), .SIGNED(0)) dut_u (.clk(clk), .rst(rst), .bus(u_if.slave));
    subt_pipe #(.WIDTH(8), .SIGNED(1)) dut_s (.clk(clk), .rst(rst), .bus(s_if.slave));

    assign s_if.in_valid  = u_if.in_valid;
    assign s_if.x         = u_if.x;
    assign s_if.y         = u_if.y;
    assign s_if.mode      = u_if.mode;
    assign s_if.out_ready = u_if.out_ready;

    wire [10:0] u_obs = {u_if.diff, u_if.neg, u_if.ovf, u_if.zero};
    wire [10:0] s_obs = {s_if.diff, s_if.neg, s_if.ovf, s_if.zero};

    always #5 clk = ~clk;

    function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] m, input bit sgn);
        int   ai, bi, d, r;
        logic ovf;
        ai  = sgn ? int'($signed(a)) : int'(a);
        bi  = sgn ? int'($signed(b)) : int'(b);
        d   = ai - bi;
        r   = d;
        ovf = 1'b0;
        if (m == 2'd0 || m == 2'd3) begin
            r = (d < 0) ? -d : d;
        end else begin
            ovf = sgn ? (d < -128 || d > 127) : (d < 0);
`ifdef SUBT_PIPE_SAT_EN
            if (m == 2'd2 && ovf) r = sgn ? ((d < 0) ? -128 : 127) : 0;
`endif
        end
        return {r[7:0], d < 0, ovf, a == b};
    endfunction

    task automatic run_beat(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                            output int lat, output logic [10:0] got_u, output logic [10:0] got_s);
        int guard;
        @(negedge clk);
        u_if.x = a; u_if.y = b; u_if.mode = m;
        u_if.in_valid = 1'b1; u_if.out_ready = 1'b1;
        #1;
        guard = 0;
        while (u_if.in_ready !== 1'b1 && guard < 20) begin
            @(negedge clk); #1; guard++;
        end
        @(posedge clk);
        @(negedge clk);
        u_if.in_valid = 1'b0;
        lat = 1;
        while (u_if.out_valid !== 1'b1 && lat < 10) begin
            @(negedge clk); lat++;
        end
        got_u = u_obs;
        got_s = s_obs;
    endtask

    task automatic test_reset();
        int stale;
        u_if.in_valid = 1'b1; u_if.x = 8'h05; u_if.y = 8'h03;
        u_if.mode = 2'd1; u_if.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        vec_cnt++;
        if ({u_if.out_valid, u_obs, s_if.out_valid, s_obs} !== 24'd0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got u=%b/%h s=%b/%h required all zero",
                     u_if.out_valid, u_obs, s_if.out_valid, s_obs);
        end
        vec_cnt++;
        if (u_if.in_ready !== 1'b1 || s_if.in_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_in_ready: got %b/%b required 1/1", u_if.in_ready, s_if.in_ready);
        end
        rst = 1'b0; u_if.in_valid = 1'b0;
        stale = 0;
        repeat (4) begin
            @(negedge clk);
            if (u_if.out_valid !== 1'b0 || s_if.out_valid !== 1'b0) stale++;
        end
        vec_cnt++;
        if (stale !== 0) begin
            err_cnt++;
            $display("FAIL reset_drop: got %0d outputs from beats offered in reset required 0", stale);
        end
    endtask

    task automatic test_modes();
        vec_t v[$];
        int lat;
        logic [10:0] gu, gs;
        v.push_back({8'h03, 8'h0A, 2'd0, {8'h07, 3'b100}, {8'h07, 3'b100}});
        v.push_back({8'h03, 8'h0A, 2'd1, {8'hF9, 3'b110}, {8'hF9, 3'b100}});
        v.push_back({8'h0A, 8'h0A, 2'd1, {8'h00, 3'b001}, {8'h00, 3'b001}});
        v.push_back({8'h80, 8'h01, 2'd1, {8'h7F, 3'b000}, {8'h7F, 3'b110}});
        v.push_back({8'h80, 8'h01, 2'd0, {8'h7F, 3'b000}, {8'h81, 3'b100}});
        v.push_back({8'h80, 8'h01, 2'd3, {8'h7F, 3'b000}, {8'h81, 3'b100}});
        v.push_back({8'h0A, 8'h03, 2'd0, {8'h07, 3'b000}, {8'h07, 3'b000}});
        foreach (v[i]) begin
            run_beat(v[i].a, v[i].b, v[i].m, lat, gu, gs);
            vec_cnt++;
            if (lat !== 2) begin
                err_cnt++;
                $display("FAIL modes_latency[%0d]: got %0d cycles required 2", i, lat);
            end
            vec_cnt++;
            if (gu !== v[i].eu || gs !== v[i].es) begin
                err_cnt++;
                $display("FAIL modes_result[%0d] x=%h y=%h mode=%0d: got u=%h s=%h required u=%h s=%h",
                         i, v[i].a, v[i].b, v[i].m, gu, gs, v[i].eu, v[i].es);
            end
        end
    endtask

    task automatic test_sat();
        vec_t v[$];
        int lat;
        logic [10:0] gu, gs;
`ifdef SUBT_PIPE_SAT_EN
        v.push_back({8'h80, 8'h01, 2'd2, {8'h7F, 3'b000}, {8'h80, 3'b110}});
        v.push_back({8'h03, 8'h0A, 2'd2, {8'h00, 3'b110}, {8'hF9, 3'b100}});
        v.push_back({8'h7F, 8'h80, 2'd2, {8'h00, 3'b110}, {8'h7F, 3'b010}});
`else
        v.push_back({8'h80, 8'h01, 2'd2, {8'h7F, 3'b000}, {8'h7F, 3'b110}});
        v.push_back({8'h03, 8'h0A, 2'd2, {8'hF9, 3'b110}, {8'hF9, 3'b100}});
        v.push_back({8'h7F, 8'h80, 2'd2, {8'hFF, 3'b110}, {8'hFF, 3'b010}});
`endif
        v.push_back({8'hFF, 8'h00, 2'd2, {8'hFF, 3'b000}, {8'hFF, 3'b100}});
        foreach (v[i]) begin
            run_beat(v[i].a, v[i].b, v[i].m, lat, gu, gs);
            vec_cnt++;
            if (gu !== v[i].eu || gs !== v[i].es || lat !== 2) begin
                err_cnt++;
                $display("FAIL sat_result[%0d] x=%h y=%h: got u=%h s=%h lat=%0d required u=%h s=%h lat=2",
                         i, v[i].a, v[i].b, gu, gs, lat, v[i].eu, v[i].es);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] xs[4], ys[4], ed[4];
        int acc, got, guard, dup;
        xs = '{8'h20, 8'h40, 8'h60, 8'h80};
        ys = '{8'h05, 8'h06, 8'h07, 8'h08};
        ed = '{8'h1B, 8'h3A, 8'h59, 8'h78};
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            u_if.out_ready = 1'b0; u_if.mode = 2'd1;
            u_if.in_valid = (acc < 4);
            u_if.x = xs[acc < 4 ? acc : 0]; u_if.y = ys[acc < 4 ? acc : 0];
            #1;
            if (u_if.in_valid && u_if.in_ready) acc++;
            @(posedge clk);
        end
        @(negedge clk); #1;
        vec_cnt++;
        if (acc !== 2 || u_if.in_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_stall: got %0d accepted in_ready=%b required 2 accepted in_ready=0",
                     acc, u_if.in_ready);
        end
        got = 0; guard = 0;
        while ((acc < 4 || got < 4) && guard < 30) begin
            @(negedge clk);
            u_if.out_ready = 1'b1;
            u_if.in_valid = (acc < 4);
            u_if.x = xs[acc < 4 ? acc : 0]; u_if.y = ys[acc < 4 ? acc : 0];
            #1;
            if (u_if.out_valid && u_if.out_ready) begin
                vec_cnt++;
                if (got >= 4 || u_obs !== {ed[got < 4 ? got : 0], 3'b000}) begin
                    err_cnt++;
                    $display("FAIL b2b_order[%0d]: got %h required %h",
                             got, u_obs, {ed[got < 4 ? got : 0], 3'b000});
                end
                got++;
            end
            if (u_if.in_valid && u_if.in_ready) acc++;
            @(posedge clk);
            guard++;
        end
        dup = 0;
        repeat (3) begin
            @(negedge clk);
            u_if.in_valid = 1'b0;
            #1;
            if (u_if.out_valid) dup++;
        end
        vec_cnt++;
        if (acc !== 4 || got !== 4 || dup !== 0) begin
            err_cnt++;
            $display("FAIL b2b_count: got accepted=%0d emitted=%0d extra=%0d required 4/4/0",
                     acc, got, dup);
        end
    endtask

    task automatic test_reset_flush();
        int stale, lat;
        logic [10:0] gu, gs;
        @(negedge clk);
        u_if.out_ready = 1'b0; u_if.mode = 2'd1;
        u_if.in_valid = 1'b1; u_if.x = 8'h11; u_if.y = 8'h01;
        @(negedge clk);
        u_if.x = 8'h22;
        @(negedge clk);
        u_if.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        vec_cnt++;
        if (u_if.out_valid !== 1'b0 || u_if.in_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL flush_during_rst: got out_valid=%b in_ready=%b required 0/1",
                     u_if.out_valid, u_if.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vec_cnt++;
        if (u_if.out_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_after_rst: got out_valid=%b required 0", u_if.out_valid);
        end
        u_if.out_ready = 1'b1;
        stale = 0;
        repeat (4) begin
            @(negedge clk);
            if (u_if.out_valid !== 1'b0) stale++;
        end
        vec_cnt++;
        if (stale !== 0) begin
            err_cnt++;
            $display("FAIL flush_stale: got %0d stale outputs required 0", stale);
        end
        run_beat(8'h30, 8'h10, 2'd1, lat, gu, gs);
        vec_cnt++;
        if (lat !== 2 || gu !== {8'h20, 3'b000}) begin
            err_cnt++;
            $display("FAIL flush_new_beat: got lat=%0d u=%h required lat=2 u=%h", lat, gu, {8'h20, 3'b000});
        end
    endtask

    task automatic test_random();
        logic [21:0] q[$];
        logic [21:0] exp_v;
        int sent, recv, cyc, tp_err;
        bit hold;
        sent = 0; recv = 0; cyc = 0; tp_err = 0; hold = 1'b0;
        while ((sent < 10000 || recv < sent) && cyc < 80000) begin
            @(negedge clk);
            if (!hold) begin
                u_if.x = 8'($urandom);
                u_if.y = 8'($urandom);
                u_if.mode = 2'($urandom_range(0, 3));
                u_if.in_valid = (sent < 10000) && ($urandom_range(0, 9) != 0);
            end
            u_if.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (u_if.out_ready && !u_if.in_ready) tp_err++;
            if (u_if.out_valid && u_if.out_ready) begin
                vec_cnt++;
                if (q.size() == 0) begin
                    err_cnt++;
                    $display("FAIL rand_extra: got u=%h s=%h with nothing outstanding", u_obs, s_obs);
                end else begin
                    exp_v = q.pop_front();
                    if ({u_obs, s_obs} !== exp_v) begin
                        err_cnt++;
                        $display("FAIL rand_result[%0d]: got u=%h s=%h required u=%h s=%h",
                                 recv, u_obs, s_obs, exp_v[21:11], exp_v[10:0]);
                    end
                end
                recv++;
            end
            if (u_if.in_valid && u_if.in_ready) begin
                q.push_back({model(u_if.x, u_if.y, u_if.mode, 1'b0),
                             model(u_if.x, u_if.y, u_if.mode, 1'b1)});
                sent++;
                hold = 1'b0;
            end else begin
                hold = u_if.in_valid;
            end
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        u_if.in_valid = 1'b0;
        vec_cnt++;
        if (sent !== 10000 || recv !== 10000 || q.size() !== 0) begin
            err_cnt++;
            $display("FAIL rand_count: got sent=%0d recv=%0d pending=%0d required 10000/10000/0",
                     sent, recv, q.size());
        end
        vec_cnt++;
        if (tp_err !== 0) begin
            err_cnt++;
            $display("FAIL rand_throughput: got %0d cycles with out_ready=1 and in_ready=0 required 0", tp_err);
        end
    endtask

    initial begin
        u_if.in_valid = 1'b0; u_if.x = '0; u_if.y = '0;
        u_if.mode = 2'd0; u_if.out_ready = 1'b1;
        test_reset();
        test_modes();
        test_sat();
        test_back_to_back();
        test_reset_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
